serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all sequential logic.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled on a rising edge, acted on only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-007 SHALL have port: c_in  input  1  carry-in; sampled only on the accepting edge.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed (RUN state).
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 SHALL have port: c_out  output  1  registered carry-out of the last completed addition.

Function
REQ-012 SHALL compute the sum one bit per clock, LSB first, through an instance of the team's one_bit_adder (a, b, c_in, sum, c_out), with a carry flip-flop feeding its c_in.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, with reset state IDLE.
REQ-014 IDLE to RUN SHALL occur on an edge with start=1: latch a and b into shift registers, load carry with c_in, and clear the bit counter.
REQ-015 RUN SHALL, on each edge, add operand bit 0 with the carry, shift the sum bit into the result register from the MSB side, shift both operands right, update the carry, and increment the counter.
REQ-016 RUN to DONE SHALL occur on the edge that processes bit WIDTH-1, which is exactly WIDTH edges after the accepting edge.
REQ-017 On that same edge, sum SHALL load the full result and c_out SHALL load the final carry.
REQ-018 DONE to IDLE SHALL occur unconditionally on the next edge, so done is high for exactly one cycle.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing and no effect on the operation in progress.
REQ-020 Changes on a, b or c_in after the accepting edge SHALL NOT affect the result.
REQ-021 sum and c_out SHALL hold their previous values throughout RUN and IDLE, and SHALL change only at completion.
REQ-022 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-023 The full result SHALL satisfy {c_out,sum} = a + b + c_in, computed as unsigned arithmetic in WIDTH+1 bits; all-ones + all-ones + 1 SHALL wrap to {1, all-ones}.
REQ-024 start held high continuously SHALL begin a new addition every WIDTH+2 cycles, with the accept occurring in IDLE.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, c_out=0, and clear the carry, counter and shift registers, without waiting for clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and outputs at 0.
REQ-027 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN defined: the block SHALL add port ovf (output, 1 bit), the registered signed-overflow flag of the last result.
REQ-029 With SERIAL_ADDER_OVF_EN, ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, update with sum, and reset to 0.
REQ-030 Macro SERIAL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 WIDTH=8; a=0x35, b=0x4A, c_in=0; pulse start -> busy for 8 cycles, done 8 edges after accept, sum=0x7F, c_out=0.
REQ-032 WIDTH=8; a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; with a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-033 Start accepted; a, b and c_in randomized and start pulsed during RUN -> the result matches the originally latched operands, and exactly one done pulse occurs.
REQ-034 rst_n driven low at bit 4 of a=0xAA, b=0x55 -> outputs 0 immediately with no done pulse; a new start then gives sum=0xFF, c_out=0.
REQ-035 SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
REQ-036 start held high for 40 cycles with WIDTH=8 -> done pulses exactly every 10 cycles, and each result is correct.

Source files
------------

// File: rtl/serial_adder.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_adder (with leaf one_bit_adder)                     |
// | Description : Bit-serial unsigned adder. Operands are latched on the     |
// |               accepting edge and summed LSB first, one bit per clock,    |
// |               through a single full-adder cell and a carry flip-flop.    |
// |               Optional macro SERIAL_ADDER_OVF_EN adds a registered       |
// |               signed-overflow output (ovf).                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  // Holds the WIDTH-1 bits already produced; the final bit joins them on the
  // completing edge, so a full-width partial register is never needed.
  logic [WIDTH-2:0]   r_res;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_s;
  logic               w_co;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_shifted;

  one_bit_adder u_bit (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry),
    .sum   (w_s),
    .c_out (w_co)
  );

  // New sum bit enters from the MSB side, pushing earlier bits toward the LSB.
  assign w_shifted = {w_s, r_res};
  assign sum       = r_sum;
  assign c_out     = r_cout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_last   = (r_cnt == c_last);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand shifting, carry tracking and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_res   <= w_shifted[WIDTH-1:1];
      r_carry <= w_co;
      r_cnt   <= r_cnt + c_one;
      if (w_last) begin
        r_sum  <= w_shifted;
        r_cout <= w_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  assign ovf = r_ovf;

  // Signed overflow: carry into the MSB (the carry flop on the last bit)
  // differs from the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if ((r_state == RUN) && w_last) r_ovf <= r_carry ^ w_co;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_adder                                            |
// | Description : Self-checking bench for serial_adder (WIDTH=8) using an    |
// |               expected-result queue filled at stimulus time.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .c_out (c_out),
    .ovf   (ovf)
`else
    .c_out (c_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: unsigned add in W+1 bits plus signed-overflow flag.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t         e;
    logic [W:0]   full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Pop the oldest expectation and compare against the completed result.
  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      ntests++; nfail++;
      $display("FAIL %s: done with empty scoreboard, sum=%h c_out=%b", name, sum, c_out);
      return;
    end
    e = sb.pop_front();
    ntests++;
    if (sum !== e.s) begin
      nfail++;
      $display("FAIL %s sum: got %h expected %h", name, sum, e.s);
    end
    ntests++;
    if (c_out !== e.c) begin
      nfail++;
      $display("FAIL %s c_out: got %b expected %b", name, c_out, e.c);
    end
`ifdef SERIAL_ADDER_OVF_EN
    ntests++;
    if (ovf !== e.v) begin
      nfail++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, e.v);
    end
`endif
  endtask

  // One complete addition; optional scrambling of inputs during RUN.
  task automatic do_add(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input bit scramble);
    logic [W-1:0] prev_s;
    logic         prev_c;
    int           ndone;
    int           nbusy;
    int           done_at;
    bit           hold_ok;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; start = 1'b1;
    prev_s = sum; prev_c = c_out;
    sb.push_back(model(ta, tb, tc));
    @(negedge clk);                 // accepting edge (edge 0) has passed
    start = 1'b0;
    ndone = 0; nbusy = 0; done_at = -1; hold_ok = 1'b1;
    for (int k = 0; k < W + 6; k++) begin
      if (busy) begin
        nbusy++;
        if (sum !== prev_s || c_out !== prev_c) hold_ok = 1'b0;
      end
      if (done) begin
        ndone++;
        done_at = k;
        check_result(name);
      end
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        start = busy ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ntests++;
    if (ndone != 1) begin
      nfail++;
      $display("FAIL %s done count: got %0d expected 1", name, ndone);
      if (ndone == 0 && sb.size() != 0) void'(sb.pop_front());
    end
    ntests++;
    if (done_at != W) begin
      nfail++;
      $display("FAIL %s done latency: got %0d expected %0d", name, done_at, W);
    end
    ntests++;
    if (nbusy != W) begin
      nfail++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, nbusy, W);
    end
    ntests++;
    if (!hold_ok) begin
      nfail++;
      $display("FAIL %s hold during RUN: got changed outputs expected %h/%b", name, prev_s, prev_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ntests++;
    if ({busy, done, c_out, sum} !== '0) begin
      nfail++;
      $display("FAIL reset outputs: got busy=%b done=%b c_out=%b sum=%h expected all 0",
               busy, done, c_out, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_add("basic_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0);
    do_add("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_add("ff_ff_cin1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    do_add("zero_cin1", 8'h00, 8'h00, 1'b1, 1'b0);
    do_add("a5_5a", 8'hA5, 8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_add("scramble_1", 8'h3C, 8'hC4, 1'b1, 1'b1);
    do_add("scramble_2", 8'h81, 8'h17, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int nd;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);      // bits 0..3 processed
    ntests++;
    if (busy !== 1'b1) begin
      nfail++;
      $display("FAIL midrun busy before reset: got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    ntests++;
    if ({busy, done, c_out, sum} !== '0) begin
      nfail++;
      $display("FAIL async reset outputs: got busy=%b done=%b c_out=%b sum=%h expected all 0",
               busy, done, c_out, sum);
    end
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) nd++;
    end
    ntests++;
    if (nd != 0) begin
      nfail++;
      $display("FAIL aborted op done pulses: got %0d expected 0", nd);
    end
    do_add("after_reset", 8'hAA, 8'h55, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int           nd;
    int           first;
    int           last;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    @(negedge clk);
    na = 8'h12; nb = 8'h34;
    a = na; b = nb; c_in = 1'b0; start = 1'b1;
    sb.push_back(model(na, nb, 1'b0));
    nd = 0; first = -1; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);               // after edge i (edge 0 is the first accept)
      if (done) begin
        nd++;
        if (first < 0) begin
          first = i;
          ntests++;
          if (i != W) begin
            nfail++;
            $display("FAIL b2b first done: got cycle %0d expected %0d", i, W);
          end
        end else begin
          ntests++;
          if (i - last != W + 2) begin
            nfail++;
            $display("FAIL b2b period: got %0d expected %0d", i - last, W + 2);
          end
        end
        last = i;
        check_result("b2b");
        if (nd < 4) begin
          na = W'($urandom); nb = W'($urandom);
          a = na; b = nb; c_in = nd[0];
          sb.push_back(model(na, nb, nd[0]));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    ntests++;
    if (nd != 4) begin
      nfail++;
      $display("FAIL b2b done count: got %0d expected 4", nd);
    end
    repeat (W + 4) @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    do_add("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    do_add("ovf_80_80", 8'h80, 8'h80, 1'b0, 1'b0);
    do_add("ovf_10_20", 8'h10, 8'h20, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
